// File: rtl/core_v2_pkg.sv
// Shared types, encodings and helpers for the multicycle_core_v2 slice.
// The state and ALU enums, the opcode constants and the immediate decoders all live here.
package core_v2_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_PASSB = 3'd6
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam int ERR_ILLEGAL       = 0;
  localparam int ERR_MISALIGN_PC   = 1;
  localparam int ERR_MISALIGN_DATA = 2;
  localparam int ERR_REG_RANGE     = 3;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic reg_in_range(input logic [4:0] idx, input int n);
    return int'(idx) < n;
  endfunction

  function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/regfile_v2.sv
// Architectural register file: two async read ports, one sync write port, one debug read port.
// Index 0 and indices at or above NUM_REGS always read as zero.
module regfile_v2
  import core_v2_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];

  assign rs1_data = (rs1_addr != 5'd0 && reg_in_range(rs1_addr, NUM_REGS))
                    ? regs[rs1_addr[AW-1:0]] : '0;
  assign rs2_data = (rs2_addr != 5'd0 && reg_in_range(rs2_addr, NUM_REGS))
                    ? regs[rs2_addr[AW-1:0]] : '0;
  assign dbg_data = (dbg_sel != 5'd0 && reg_in_range(dbg_sel, NUM_REGS))
                    ? regs[dbg_sel[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0 && reg_in_range(wr_addr, NUM_REGS)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/multicycle_core_v2.sv
// Multicycle RV32I-subset core: FSM, holding registers and one shared req/ack memory port.
// Stops in HALT on EBREAK/ECALL or on any flagged error; only reset leaves HALT.
module multicycle_core_v2
  import core_v2_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             halt,
  output logic [31:0]      pc_out,
  output logic [2:0]       state_vector,
  output logic [ERR_W-1:0] error_vector,
  input  logic [4:0]       dbg_reg_sel,
  output logic [31:0]      dbg_reg_data
);

  state_t           state;
  logic [31:0]      pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [ERR_W-1:0] err;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [31:0] rf_rd1, rf_rd2, rf_wdata;
  logic        rf_we;

  regfile_v2 #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rf_rd1),
    .rs2_data (rf_rd2),
    .we       (rf_we),
    .wr_addr  (rd),
    .wr_data  (rf_wdata),
    .dbg_sel  (dbg_reg_sel),
    .dbg_data (dbg_reg_data)
  );

  logic is_sys, legal, uses_rd, uses_rs1, uses_rs2, bad_reg;
  always_comb begin
    legal    = 1'b0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_sys   = (ir == INSN_EBREAK) || (ir == INSN_ECALL);
    case (opcode)
      OPC_LUI:    begin legal = 1'b1; uses_rd = 1'b1; end
      OPC_JAL:    begin legal = 1'b1; uses_rd = 1'b1; end
      OPC_BRANCH: begin
        legal    = (f3 == F3_BEQ) || (f3 == F3_BNE);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD:   begin legal = (f3 == F3_LW); uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OPC_STORE:  begin legal = (f3 == F3_SW); uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OPIMM:  begin legal = (f3 == F3_ADD); uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OPC_OP: begin
        legal = ((f7 == F7_BASE) && (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_XOR ||
                                     f3 == F3_OR  || f3 == F3_AND)) ||
                ((f7 == F7_SUB) && (f3 == F3_ADD));
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    bad_reg = (uses_rd  && !reg_in_range(rd,  NUM_REGS)) ||
              (uses_rs1 && !reg_in_range(rs1, NUM_REGS)) ||
              (uses_rs2 && !reg_in_range(rs2, NUM_REGS));
  end

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res;
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_i(ir);
    case (opcode)
      OPC_OP: begin
        alu_b = b_reg;
        case (f3)
          F3_SLT:  alu_op = ALU_SLT;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: alu_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        endcase
      end
      OPC_LUI: begin
        alu_op = ALU_PASSB;
        alu_b  = imm_u(ir);
      end
      OPC_STORE: alu_b = imm_s(ir);
      default: ;
    endcase
    alu_res = alu_compute(alu_op, a_reg, alu_b);
  end

  logic [31:0] pc_plus4, jal_target;
  logic        br_taken;
  assign pc_plus4   = pc + 32'd4;
  assign jal_target = pc + imm_j(ir);
  assign br_taken   = f3[0] ? (a_reg != b_reg) : (a_reg == b_reg);

  // JAL links in EXEC only when its target is legal; everything else writes back in WB.
  assign rf_we    = (state == WB) ||
                    (state == EXEC && opcode == OPC_JAL && jal_target[1:0] == 2'b00);
  assign rf_wdata = (state == WB) ? ((opcode == OPC_LOAD) ? mdr : alu_out) : pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      err     <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ack) begin
          ir    <= mem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a_reg   <= rf_rd1;
          b_reg   <= rf_rd2;
          alu_out <= pc + imm_b(ir);
          if (is_sys) begin
            state <= HALT;
          end else if (!legal) begin
            err[ERR_ILLEGAL] <= 1'b1;
            state            <= HALT;
          end else if (bad_reg) begin
            err[ERR_REG_RANGE] <= 1'b1;
            state              <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            OPC_LOAD, OPC_STORE: begin
              alu_out <= alu_res;
              if (alu_res[1:0] != 2'b00) begin
                err[ERR_MISALIGN_DATA] <= 1'b1;
                state                  <= HALT;
              end else begin
                state <= MEM;
              end
            end
            OPC_BRANCH: begin
              if (!br_taken) begin
                pc    <= pc_plus4;
                state <= FETCH;
              end else if (alu_out[1:0] != 2'b00) begin
                err[ERR_MISALIGN_PC] <= 1'b1;
                state                <= HALT;
              end else begin
                pc    <= alu_out;
                state <= FETCH;
              end
            end
            OPC_JAL: begin
              if (jal_target[1:0] != 2'b00) begin
                err[ERR_MISALIGN_PC] <= 1'b1;
                state                <= HALT;
              end else begin
                pc    <= jal_target;
                state <= FETCH;
              end
            end
            default: begin
              alu_out <= alu_res;
              state   <= WB;
            end
          endcase
        end
        MEM: if (mem_ack) begin
          if (opcode == OPC_STORE) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end else begin
            mdr   <= mem_rdata;
            state <= WB;
          end
        end
        WB: begin
          pc    <= pc_plus4;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Memory handshake: a transfer completes on a rising edge where mem_req && mem_ack.
  // Request fields derive only from state/pc/alu_out/b_reg, which are frozen until that
  // edge, so they hold steady across wait states; reset forces all of them low at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (state == FETCH) begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end else if (state == MEM) begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
        if (opcode == OPC_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = b_reg;
        end
      end
    end
  end

  assign halt         = (state == HALT);
  assign pc_out       = pc;
  assign state_vector = state;
  assign error_vector = err;

endmodule

// File: doc/multicycle_core_v2.md
Name: multicycle_core_v2

Overview:
Parametrised second-generation multicycle RV32I-subset core. It integrates an FSM controller, register file, ALU, and the IR/PC/A/B/ALUOut holding registers behind one shared req/ack memory port that tolerates wait states. It sits under the board toplevel, which supplies memory and debug display. It adds configurable reset vector and register count, halt on EBREAK/ECALL, and a sticky error vector.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset.
NUM_REGS, 32, architectural register count; legal values are 16 (RV32E) and 32.
ERR_W, 8, width of error_vector.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
mem_req  out  1  memory transaction request; held until accepted.
mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req is high.
mem_addr  out  32  word-aligned byte address.
mem_wdata  out  32  store data.
mem_ack  in  1  transaction completes in the cycle where mem_req and mem_ack are both 1; may be combinational.
mem_rdata  in  32  read data; sampled in the completing cycle.
halt  out  1  core stopped, either by EBREAK/ECALL or by an error.
pc_out  out  32  address of the current instruction.
state_vector  out  3  encoded FSM state.
error_vector  out  ERR_W  sticky error flags.
dbg_reg_sel  in  5  register index for debug read.
dbg_reg_data  out  32  combinational read of register dbg_reg_sel; returns 0 if the index is out of range.

Behaviour:
- Reset (async, rst=0):
  - state=FETCH, pc=RESET_PC, all registers 0, IR=0, error_vector=0, halt=0.
  - mem_req, mem_we, mem_addr and mem_wdata drop to 0 immediately, even in the middle of a transaction.
- Supported instructions: LUI, JAL, BEQ, BNE, LW, SW, ADDI, ADD, SUB, AND, OR, XOR, SLT, EBREAK/ECALL.
- x0 always reads 0; writes to x0 are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Stay until ack, then latch IR and go to DECODE.
- DECODE:
  - Latch A=rs1 and B=rs2; compute branch target ALUOut = pc + immB.
  - EBREAK/ECALL -> HALT.
  - Illegal opcode/funct -> set err[0] -> HALT.
  - Any rs1/rs2/rd index >= NUM_REGS -> set err[3] -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - R-type/ADDI/LUI: ALUOut = result -> WB.
  - LW/SW: ALUOut = A + imm. If ALUOut[1:0] != 0, set err[2] -> HALT; otherwise -> MEM.
  - BEQ/BNE: if taken, pc = target; else pc += 4 -> FETCH.
  - JAL: rd = pc+4, pc = pc + immJ -> FETCH.
  - A taken-branch or JAL target with [1:0] != 0 sets err[1] -> HALT; pc is not updated.
- MEM:
  - SW: mem_req=1, mem_we=1, addr=ALUOut, wdata=B. On ack, pc += 4 -> FETCH.
  - LW: mem_we=0. On ack, latch MDR -> WB.
- WB: rd = ALUOut or MDR; pc += 4 -> FETCH.
- Outputs are stable while waiting: mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_ack=0.
- Cycle counts with zero-wait memory: R/I/LUI 4, LW 5, SW 4, branch 3, JAL 3. Each memory wait cycle adds 1.
- SLT is signed. All arithmetic is 32-bit and wraps; there is no overflow trap.
- HALT is terminal until reset: halt=1, mem_req=0, and the register file is still readable through the debug port.
- error_vector bits: 0 illegal, 1 misaligned jump/branch target, 2 misaligned data, 3 register index out of range; remaining bits 0. Flags are sticky.

Decomposition:
- core_v2_pkg:
  - state_t enum (FETCH..HALT).
  - alu_op_t enum.
  - Opcode/funct3/funct7 localparams.
  - Error bit index localparams.
  - Immediate-extraction functions (I, S, B, J, U).
- Sub-module regfile_v2:
  - Parameter NUM_REGS.
  - Two combinational read ports, one synchronous write port, plus the debug read port.
  - x0 forced to zero.
  - Async active-low reset to all-zero.

Test Plan:
- RESET_PC=0x100; release rst -> first mem_req=1 with mem_addr=0x100, mem_we=0; halt=0; error_vector=0.
- ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; EBREAK, with zero-wait memory -> dbg x3=12, each ALU instruction takes 4 cycles, then halt=1 and pc_out=0x10C.
- SW x3,8(x0) then LW x4,8(x0), ack delayed 3 cycles -> store seen as addr=0x8, wdata=12, mem_we=1, held stable during the wait; x4=12; LW takes 11 cycles.
- BEQ x1,x1,-8 at 0x20 -> next fetch 0x18. BNE x1,x1,+8 at 0x20 -> next fetch 0x24. JAL x5,+16 at 0x30 -> x5=0x34, next fetch 0x40.
- Instruction 0x0000_0000 -> error_vector[0]=1, halt=1, no further mem_req. LW with address 0x6 -> error_vector[2]=1, no memory access.
- rst pulled low during a LW wait -> mem_req=0 in the same cycle; after release, fetch restarts at RESET_PC with x1..x31=0. With NUM_REGS=16, ADDI x20,x0,1 -> error_vector[3]=1, halt=1.
